ysyx_23060201_lsu: RTL and testbench

Load/store unit directly upstream of the DPI-backed data memory.
- Accepts one memory op at a time from the execute stage over a valid/ready handshake.
- Drives the memory's read/write strobes, word address, byte mask and lane-aligned write data.
- Captures read data after a fixed latency, extracts and extends the addressed byte/half/word, and returns the result to writeback over a second valid/ready handshake.

---
 rtl/ysyx_23060201_lsu_if.sv | 52 +++++
 rtl/ysyx_23060201_lsu.sv | 178 +++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_lsu_if.sv
// Bundles the three links of the load/store unit:
//   in_*   : execute stage -> LSU request, valid/ready handshake
//   out_*  : LSU -> writeback response, valid/ready handshake
//   mem_*  : LSU <-> data memory read/write strobes, addresses, masks and data
// Modports: slave is the LSU's view; master is the view of its surroundings
// (execute, writeback and memory together).
interface ysyx_23060201_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_load;
  logic                  in_store;
  logic [2:0]            in_funct3;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [4:0]            in_rd;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic [4:0]            out_rd;
  logic                  out_err;

  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_rmask;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [7:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready,
    output mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready,
    input  mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit in front of the data memory. Takes one op at a time from
// execute, drives the memory strobes for exactly as long as needed, and hands
// the (extended) load result or an error flag back to writeback.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : request / response / memory signals (see ysyx_23060201_lsu_if)
// Only in_ready is combinational (state == idle); every other output is a
// register.
module ysyx_23060201_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  ysyx_23060201_lsu_if.slave bus
);

  localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  out_valid_q;
  logic                  out_err_q;
  logic [DATA_WIDTH-1:0] out_rdata_q;
  logic [4:0]            out_rd_q;
  logic                  mem_ren_q;
  logic [ADDR_WIDTH-1:0] mem_raddr_q;
  logic [7:0]            mem_rmask_q;
  logic                  mem_wen_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [7:0]            mem_wmask_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // Request decode
  logic [1:0]            off;
  logic                  sz_byte, sz_half, sz_word;
  logic                  f3_ok, align_ok, op_ok;
  logic [3:0]            mask4;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] wdata_sh;

  assign off       = bus.in_addr[1:0];
  assign word_addr = {bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
  assign wdata_sh  = bus.in_wdata << {off, 3'b000};

  always_comb begin
    sz_byte = 1'b0;
    sz_half = 1'b0;
    sz_word = 1'b0;
    f3_ok   = 1'b0;
    case (bus.in_funct3)
      3'b000: begin sz_byte = 1'b1; f3_ok = 1'b1;        end
      3'b001: begin sz_half = 1'b1; f3_ok = 1'b1;        end
      3'b010: begin sz_word = 1'b1; f3_ok = 1'b1;        end
      // Unsigned variants exist only for loads.
      3'b100: begin sz_byte = 1'b1; f3_ok = bus.in_load; end
      3'b101: begin sz_half = 1'b1; f3_ok = bus.in_load; end
      default: ;
    endcase
    align_ok = sz_byte | (sz_half & ~off[0]) | (sz_word & (off == 2'b00));
    op_ok    = (bus.in_load ^ bus.in_store) & f3_ok & align_ok;
    if (sz_byte)      mask4 = 4'b0001 << off;
    else if (sz_half) mask4 = 4'b0011 << off;
    else if (sz_word) mask4 = 4'b1111;
    else              mask4 = 4'b0000;
  end

  // Load data extraction from the lane selected by the latched offset
  logic [DATA_WIDTH-1:0] rd_sh, load_ext;

  assign rd_sh = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  load_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b010:  load_ext = rd_sh;
      3'b100:  load_ext = {24'b0, rd_sh[7:0]};
      3'b101:  load_ext = {16'b0, rd_sh[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
      out_rd_q    <= '0;
      mem_ren_q   <= 1'b0;
      mem_raddr_q <= '0;
      mem_rmask_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            off_q    <= off;
            f3_q     <= bus.in_funct3;
            out_rd_q <= bus.in_rd;
            if (!op_ok) begin
              // Bad ops never touch memory; answer immediately.
              state_q     <= StResp;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_rdata_q <= '0;
            end else if (bus.in_load) begin
              state_q     <= StRd;
              mem_ren_q   <= 1'b1;
              mem_raddr_q <= word_addr;
              mem_rmask_q <= {4'b0000, mask4};
              cnt_q       <= CntW'(RD_LATENCY - 1);
            end else begin
              state_q     <= StWr;
              mem_wen_q   <= 1'b1;
              mem_waddr_q <= word_addr;
              mem_wmask_q <= {4'b0000, mask4};
              mem_wdata_q <= wdata_sh;
            end
          end
        end
        StRd: begin
          // Read data is valid only in the last cycle of the enable window.
          if (cnt_q == '0) begin
            state_q     <= StResp;
            mem_ren_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_rdata_q <= load_ext;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWr: begin
          state_q     <= StResp;
          mem_wen_q   <= 1'b0;
          out_valid_q <= 1'b1;
          out_err_q   <= 1'b0;
          out_rdata_q <= '0;
        end
        StResp: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_rdata = out_rdata_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_rmask = mem_rmask_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for ysyx_23060201_lsu: two instances (read latency 1 and 3), each with
// its own word memory, checked against a byte-addressed reference model.
module tb_ysyx_23060201_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Per-instance stimulus and observed outputs
  logic        in_valid_a [2];
  logic        in_load_a  [2];
  logic        in_store_a [2];
  logic [2:0]  f3_a       [2];
  logic [31:0] addr_a     [2];
  logic [31:0] wdata_a    [2];
  logic [4:0]  rd_a       [2];
  logic        out_ready_a[2];

  logic        in_ready_o [2];
  logic        out_valid_o[2];
  logic        out_err_o  [2];
  logic [31:0] out_rdata_o[2];
  logic [4:0]  out_rd_o   [2];
  logic        ren_o      [2];
  logic        wen_o      [2];
  logic [31:0] raddr_o    [2];
  logic [31:0] waddr_o    [2];
  logic [31:0] wdata_o    [2];
  logic [7:0]  rmask_o    [2];
  logic [7:0]  wmask_o    [2];

  logic [31:0] env_mem [2][64];   // memory seen by the DUT (word array)
  logic [7:0]  ref_b   [2][256];  // reference model memory (byte array)
  int          lat_a   [2] = '{1, 3};

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int Lat = (k == 0) ? 1 : 3;
    ysyx_23060201_lsu_if bus ();
    ysyx_23060201_lsu #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .RD_LATENCY(Lat)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.in_valid  = in_valid_a[k];
    assign bus.in_load   = in_load_a[k];
    assign bus.in_store  = in_store_a[k];
    assign bus.in_funct3 = f3_a[k];
    assign bus.in_addr   = addr_a[k];
    assign bus.in_wdata  = wdata_a[k];
    assign bus.in_rd     = rd_a[k];
    assign bus.out_ready = out_ready_a[k];
    assign in_ready_o[k]  = bus.in_ready;
    assign out_valid_o[k] = bus.out_valid;
    assign out_err_o[k]   = bus.out_err;
    assign out_rdata_o[k] = bus.out_rdata;
    assign out_rd_o[k]    = bus.out_rd;
    assign ren_o[k]       = bus.mem_ren;
    assign wen_o[k]       = bus.mem_wen;
    assign raddr_o[k]     = bus.mem_raddr;
    assign waddr_o[k]     = bus.mem_waddr;
    assign wdata_o[k]     = bus.mem_wdata;
    assign rmask_o[k]     = bus.mem_rmask;
    assign wmask_o[k]     = bus.mem_wmask;

    // Memory returns real data only once ren has been high Lat cycles.
    int unsigned ren_run = 0;
    always @(posedge clk) begin
      ren_run <= bus.mem_ren ? ren_run + 1 : 0;
      if (bus.mem_wen)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) env_mem[k][bus.mem_waddr[7:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
    assign bus.mem_rdata = (bus.mem_ren && ren_run == Lat - 1) ?
                           env_mem[k][bus.mem_raddr[7:2]] : 32'hA5A5_5A5A;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of the op in flight
  bit          exp_active = 1'b0;
  int          exp_k, exp_kind, exp_lat, exp_ren_n, exp_wen_n;  // kind: 0 err, 1 load, 2 store
  logic [31:0] exp_raddr, exp_waddr, exp_wdata, exp_rdata;
  logic [7:0]  exp_rmask, exp_wmask;
  logic        exp_err;
  logic [4:0]  exp_rd;
  int          ren_cnt, wen_cnt;
  bit          seen_valid;
  logic [31:0] last_rdata, last_raddr, last_waddr, last_wdata;
  logic [7:0]  last_rmask, last_wmask;
  logic        last_err;
  int          exp_sz;

  task automatic preload(input int k, input int idx, input logic [31:0] w);
    env_mem[k][idx] = w;
    for (int j = 0; j < 4; j++) ref_b[k][4*idx + j] = w[8*j +: 8];
  endtask

  task automatic set_model(input int k, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    int sz, off, a;
    bit f3ok, legal, sgn;
    logic [31:0] v;
    off = int'(addr[1:0]);
    a   = int'(addr[7:0]);
    sz = 0; f3ok = 1'b0;
    case (f3)
      3'd0: begin sz = 1; f3ok = 1'b1; end
      3'd1: begin sz = 2; f3ok = 1'b1; end
      3'd2: begin sz = 4; f3ok = 1'b1; end
      3'd4: begin sz = 1; f3ok = ld;   end
      3'd5: begin sz = 2; f3ok = ld;   end
      default: ;
    endcase
    legal = (ld != st) && f3ok && ((off % sz) == 0);
    sgn   = (f3 < 3'd4);
    v = '0;
    if (legal)
      for (int i = 0; i < sz; i++) v = v | (32'(ref_b[k][a + i]) << (8 * i));
    if (legal && sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    exp_k     = k;
    exp_sz    = sz;
    exp_kind  = !legal ? 0 : (ld ? 1 : 2);
    exp_err   = !legal;
    exp_rd    = rd;
    exp_rdata = (exp_kind == 1) ? v : 32'h0;
    exp_raddr = addr & 32'hFFFF_FFFC;
    exp_waddr = addr & 32'hFFFF_FFFC;
    exp_rmask = 8'(((1 << sz) - 1) << off);
    exp_wmask = exp_rmask;
    exp_wdata = wdata << (8 * off);
    exp_lat   = (exp_kind == 0) ? 1 : (exp_kind == 1 ? 1 + lat_a[k] : 2);
    exp_ren_n = (exp_kind == 1) ? lat_a[k] : 0;
    exp_wen_n = (exp_kind == 2) ? 1 : 0;
  endtask

  task automatic accept(input int k, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    set_model(k, ld, st, f3, addr, wdata, rd);
    @(negedge clk);
    chk("accept_in_ready", in_ready_o[k], 1);
    in_valid_a[k] = 1'b1; in_load_a[k] = ld; in_store_a[k] = st; f3_a[k] = f3;
    addr_a[k] = addr; wdata_a[k] = wdata; rd_a[k] = rd;
    @(posedge clk);
    #1;
    in_valid_a[k] = 1'b0; in_load_a[k] = $urandom_range(0, 1); in_store_a[k] = $urandom_range(0, 1);
    f3_a[k] = 3'($urandom); addr_a[k] = $urandom; wdata_a[k] = $urandom; rd_a[k] = 5'($urandom);
    ren_cnt = 0; wen_cnt = 0; seen_valid = 1'b0;
    exp_active = 1'b1;
  endtask

  task automatic do_op(input int k, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int delay);
    int n;
    accept(k, ld, st, f3, addr, wdata, rd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_o[k] && n < 20);
    chk("latency", n, exp_lat);
    repeat (delay) begin
      @(negedge clk);
      chk("hold_valid", out_valid_o[k], 1);
      chk("hold_in_ready", in_ready_o[k], 0);
    end
    last_rdata = out_rdata_o[k];
    last_err   = out_err_o[k];
    out_ready_a[k] = 1'b1;
    @(posedge clk);
    #1;
    exp_active = 1'b0;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    chk("done_valid", out_valid_o[k], 0);
    chk("done_in_ready", in_ready_o[k], 1);
    if (exp_kind == 2)
      for (int i = 0; i < exp_sz; i++) ref_b[k][int'(addr[7:0]) + i] = wdata[8*i +: 8];
  endtask

  // Per-cycle comparison against the expected op
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("ren_wen_exclusive", 32'(ren_o[k] & wen_o[k]), 0);
        if (!exp_active || k != exp_k) begin
          chk("idle_ren", ren_o[k], 0);
          chk("idle_wen", wen_o[k], 0);
          chk("idle_out_valid", out_valid_o[k], 0);
          chk("idle_in_ready", in_ready_o[k], 1);
        end else begin
          chk("busy_in_ready", in_ready_o[k], 0);
          if (ren_o[k]) begin
            ren_cnt++;
            chk("ren_kind", exp_kind, 1);
            chk("raddr", raddr_o[k], exp_raddr);
            chk("rmask", rmask_o[k], exp_rmask);
            last_raddr = raddr_o[k];
            last_rmask = rmask_o[k];
          end
          if (wen_o[k]) begin
            wen_cnt++;
            chk("wen_kind", exp_kind, 2);
            chk("waddr", waddr_o[k], exp_waddr);
            chk("wmask", wmask_o[k], exp_wmask);
            chk("wdata", wdata_o[k], exp_wdata);
            last_waddr = waddr_o[k];
            last_wmask = wmask_o[k];
            last_wdata = wdata_o[k];
          end
          if (out_valid_o[k]) begin
            chk("out_rdata", out_rdata_o[k], exp_rdata);
            chk("out_rd", out_rd_o[k], exp_rd);
            chk("out_err", out_err_o[k], exp_err);
            if (!seen_valid) begin
              seen_valid = 1'b1;
              chk("ren_cycles", ren_cnt, exp_ren_n);
              chk("wen_cycles", wen_cnt, exp_wen_n);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r;
    logic ld, st;
    logic [2:0] f3;
    for (int kk = 0; kk < 2; kk++) begin
      for (int i = 0; i < 64; i++) preload(kk, i, $urandom);
      preload(kk, 4, 32'hDEAD_BEEF);
      preload(kk, 8, 32'hCAFE_F00D);
      in_valid_a[kk] = 1'b0; in_load_a[kk] = 1'b0; in_store_a[kk] = 1'b0; f3_a[kk] = 3'd0;
      addr_a[kk] = '0; wdata_a[kk] = '0; rd_a[kk] = '0; out_ready_a[kk] = 1'b0;
    end
    // Reset with a pending request that must be ignored
    rst = 1'b1;
    in_valid_a[0] = 1'b1; in_load_a[0] = 1'b1; f3_a[0] = 3'd2; addr_a[0] = 32'h8000_0010;
    repeat (2) @(posedge clk);
    #1;
    for (int kk = 0; kk < 2; kk++) begin
      chk("rst_in_ready", in_ready_o[kk], 1);
      chk("rst_out_valid", out_valid_o[kk], 0);
      chk("rst_out_err", out_err_o[kk], 0);
      chk("rst_out_rdata", out_rdata_o[kk], 0);
      chk("rst_out_rd", out_rd_o[kk], 0);
      chk("rst_ren", ren_o[kk], 0);
      chk("rst_wen", wen_o[kk], 0);
      chk("rst_raddr", raddr_o[kk], 0);
      chk("rst_rmask", rmask_o[kk], 0);
      chk("rst_waddr", waddr_o[kk], 0);
      chk("rst_wmask", wmask_o[kk], 0);
      chk("rst_wdata", wdata_o[kk], 0);
    end
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // Directed cases on the latency-1 instance, pinned to literal values
    do_op(0, 1, 0, 3'd2, 32'h8000_0010, 0, 5'd3, 0);
    chk("lw_lit_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lw_lit_raddr", last_raddr, 32'h8000_0010);
    chk("lw_lit_rmask", last_rmask, 8'h0F);
    do_op(0, 1, 0, 3'd0, 32'h8000_0013, 0, 5'd4, 1);
    chk("lb_lit_rmask", last_rmask, 8'h08);
    chk("lb_lit_rdata", last_rdata, 32'hFFFF_FFDE);
    do_op(0, 1, 0, 3'd4, 32'h8000_0013, 0, 5'd5, 0);
    chk("lbu_lit_rdata", last_rdata, 32'h0000_00DE);
    do_op(0, 1, 0, 3'd1, 32'h8000_0012, 0, 5'd6, 0);
    chk("lh_lit_rdata", last_rdata, 32'hFFFF_DEAD);
    do_op(0, 1, 0, 3'd5, 32'h8000_0010, 0, 5'd7, 0);
    chk("lhu_lit_rdata", last_rdata, 32'h0000_BEEF);
    do_op(0, 0, 1, 3'd1, 32'h8000_0022, 32'h1234_5678, 5'd8, 0);
    chk("sh_lit_waddr", last_waddr, 32'h8000_0020);
    chk("sh_lit_wmask", last_wmask, 8'h0C);
    chk("sh_lit_wdata", last_wdata, 32'h5678_0000);
    chk("sh_lit_rdata", last_rdata, 32'h0);
    do_op(0, 1, 0, 3'd2, 32'h8000_0020, 0, 5'd9, 0);
    chk("lw_after_sh_lit", last_rdata, 32'h5678_F00D);
    do_op(0, 1, 0, 3'd2, 32'h8000_0011, 0, 5'd10, 0);
    chk("err_misalign_lit", last_err, 1'b1);
    chk("err_misalign_rdata", last_rdata, 32'h0);
    do_op(0, 1, 0, 3'd3, 32'h8000_0010, 0, 5'd11, 0);
    chk("err_f3_lit", last_err, 1'b1);

    // Latency-3 instance: backpressure, then reset during the read
    do_op(1, 1, 0, 3'd2, 32'h8000_0010, 0, 5'd12, 5);
    chk("bp_lit_rdata", last_rdata, 32'hDEAD_BEEF);
    accept(1, 1, 0, 3'd2, 32'h8000_0010, 0, 5'd13);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ren", ren_o[1], 0);
    chk("midrst_valid", out_valid_o[1], 0);
    chk("midrst_in_ready", in_ready_o[1], 1);
    repeat (3) @(negedge clk);
    do_op(1, 1, 0, 3'd2, 32'h8000_0010, 0, 5'd14, 0);
    chk("post_rst_lit", last_rdata, 32'hDEAD_BEEF);

    // Random ops on both instances
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      ld = (r == 1) || (r >= 2 && r <= 5);
      st = (r == 1) || (r >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) f3 = 3'($urandom_range(0, 4)) + ((r & 1) ? 3'd0 : 3'd0);
      else f3 = 3'($urandom_range(0, 2));
      if (ld && f3 == 3'd3) f3 = 3'd5;
      do_op(k, ld, st, f3, 32'h8000_0000 | $urandom_range(0, 255), $urandom,
            5'($urandom), $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
